// File: rtl/sram_1rw1r_param.sv
// Behavioural 1RW+1R SRAM: port0 read/write with lane masks, port1 read-only,
// selectable read latency, write/read collision forwarding and a post-reset clear sequencer.
module sram_1rw1r_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int MASK_WIDTH     = 1,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [MASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  init_busy
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_W = DATA_WIDTH / MASK_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % MASK_WIDTH != 0) begin : g_bad_mask
        $error("sram_1rw1r_param: DATA_WIDTH must be divisible by MASK_WIDTH");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_busy_q, init_busy_d;
    logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
    logic                  s1_vld0_q, s1_vld0_d;
    logic                  s1_vld1_q, s1_vld1_d;
    logic [DATA_WIDTH-1:0] s1_data0_q, s1_data0_d;
    logic [DATA_WIDTH-1:0] s1_data1_q, s1_data1_d;

    logic                  ready;
    logic                  wr0_en;
    logic                  rd0_en;
    logic                  rd1_en;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd0_word;
    logic [DATA_WIDTH-1:0] rd1_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign ready  = (state_q == READY);
    assign wr0_en = ready && !csb0 && !web0;
    assign rd0_en = ready && !csb0 && web0;
    assign rd1_en = ready && !csb1;

    // Merged word is both what gets written and what a bypassed port1 read returns.
    always_comb begin
        merged_word = mem[addr0];
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (wmask0[i]) begin
                merged_word[i*LANE_W +: LANE_W] = din0[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rd0_word = mem[addr0];
        rd1_word = mem[addr1];
        if (BYPASS != 0 && wr0_en && addr0 == addr1) begin
            rd1_word = merged_word;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr0;
        mem_wdata = merged_word;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wr0_en) begin
            mem_we = 1'b1;
        end
    end

    // Array contents deliberately survive rst; only the sequencer zeroes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_d = init_busy_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (&cnt_q) begin
                state_d     = READY;
                init_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q       <= '0;
            init_busy_q <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Latency 1 loads dout at the launch edge; latency 2 goes through stage1 first.
    always_comb begin
        dout0_d    = dout0_q;
        dout1_d    = dout1_q;
        s1_vld0_d  = 1'b0;
        s1_vld1_d  = 1'b0;
        s1_data0_d = s1_data0_q;
        s1_data1_d = s1_data1_q;
        if (READ_LATENCY == 1) begin
            if (rd0_en) dout0_d = rd0_word;
            if (rd1_en) dout1_d = rd1_word;
        end else begin
            s1_vld0_d = rd0_en;
            s1_vld1_d = rd1_en;
            if (rd0_en) s1_data0_d = rd0_word;
            if (rd1_en) s1_data1_d = rd1_word;
            if (s1_vld0_q) dout0_d = s1_data0_q;
            if (s1_vld1_q) dout1_d = s1_data1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout0_q    <= '0;
            dout1_q    <= '0;
            s1_vld0_q  <= 1'b0;
            s1_vld1_q  <= 1'b0;
            s1_data0_q <= '0;
            s1_data1_q <= '0;
        end else begin
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
            s1_vld0_q  <= s1_vld0_d;
            s1_vld1_q  <= s1_vld1_d;
            s1_data0_q <= s1_data0_d;
            s1_data1_q <= s1_data1_d;
        end
    end

    assign dout0     = dout0_q;
    assign dout1     = dout1_q;
    assign init_busy = init_busy_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: instance a uses defaults (8x1024, latency 1, bypass, clear);
// instance b is 32-bit, 4 lanes, latency 2, no bypass, no clear.
module tb_sram_1rw1r_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, csb0_a, web0_a, csb1_a, init_busy_a;
    logic [0:0]  wmask0_a;
    logic [9:0]  addr0_a, addr1_a;
    logic [7:0]  din0_a, dout0_a, dout1_a;

    logic        rst_b, csb0_b, web0_b, csb1_b, init_busy_b;
    logic [3:0]  wmask0_b;
    logic [9:0]  addr0_b, addr1_b;
    logic [31:0] din0_b, dout0_b, dout1_b;

    sram_1rw1r_param dut_a (
        .clk(clk), .rst(rst_a), .csb0(csb0_a), .web0(web0_a), .wmask0(wmask0_a),
        .addr0(addr0_a), .din0(din0_a), .dout0(dout0_a), .csb1(csb1_a),
        .addr1(addr1_a), .dout1(dout1_a), .init_busy(init_busy_a)
    );

    sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .MASK_WIDTH(4),
        .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .csb0(csb0_b), .web0(web0_b), .wmask0(wmask0_b),
        .addr0(addr0_b), .din0(din0_b), .dout0(dout0_b), .csb1(csb1_b),
        .addr1(addr1_b), .dout1(dout1_b), .init_busy(init_busy_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       csb0;
        logic       web0;
        logic       wm;
        logic [9:0] a0;
        logic [7:0] d0;
        logic       csb1;
        logic [9:0] a1;
        logic       chk0;
        logic [7:0] e0;
        logic       chk1;
        logic [7:0] e1;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic csb0, input logic web0, input logic wm,
                           input logic [9:0] a0, input logic [7:0] d0,
                           input logic csb1, input logic [9:0] a1);
        csb0_a = csb0; web0_a = web0; wmask0_a = wm;
        addr0_a = a0; din0_a = d0; csb1_a = csb1; addr1_a = a1;
    endtask

    task automatic idle_a;
        drive_a(1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 10'h000);
    endtask

    task automatic drive_b(input logic csb0, input logic web0, input logic [3:0] wm,
                           input logic [9:0] a0, input logic [31:0] d0,
                           input logic csb1, input logic [9:0] a1);
        csb0_b = csb0; web0_b = web0; wmask0_b = wm;
        addr0_b = a0; din0_b = d0; csb1_b = csb1; addr1_b = a1;
    endtask

    task automatic idle_b;
        drive_b(1'b1, 1'b1, 4'h0, 10'h000, 32'h0, 1'b1, 10'h000);
    endtask

    // Counts edges from reset release until init_busy falls; tries a write of
    // 0xFF@0x010 (plus a port1 read) well after the sequencer has passed 0x010.
    task automatic clear_run(output int n);
        n = 0;
        while (n < 2000) begin
            tick();
            n++;
            if (!init_busy_a) break;
            if (n == 500) drive_a(1'b0, 1'b0, 1'b1, 10'h010, 8'hFF, 1'b0, 10'h010);
            else idle_a();
        end
        idle_a();
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 10'h00A, 8'h55, 1'b1, 10'h000, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 10'h00B, 8'h44, 1'b1, 10'h000, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 10'h00C, 8'h33, 1'b1, 10'h000, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 10'h000, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 10'h000, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 10'h000, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 10'h000, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 10'h00A, 8'h00, 1'b1, 10'h000, 1'b1, 8'h55, 1'b1, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 10'h00B, 8'h00, 1'b1, 10'h000, 1'b1, 8'h44, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 10'h00C, 8'h00, 1'b1, 10'h000, 1'b1, 8'h33, 1'b1, 8'h00};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 10'h000, 1'b1, 8'h33, 1'b1, 8'h00};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 10'h000, 1'b1, 8'h33, 1'b1, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 10'h005, 8'hA5, 1'b0, 10'h005, 1'b1, 8'h33, 1'b1, 8'hA5};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 10'h00B, 8'h00, 1'b0, 10'h00B, 1'b1, 8'h44, 1'b1, 8'h44};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 10'h00A, 1'b1, 8'h44, 1'b1, 8'h55};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 10'h00A, 8'hEE, 1'b1, 10'h000, 1'b1, 8'h44, 1'b1, 8'h55};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 10'h00A, 8'h00, 1'b0, 10'h005, 1'b1, 8'h55, 1'b1, 8'hA5};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 10'h00D, 8'h99, 1'b0, 10'h00C, 1'b1, 8'h55, 1'b1, 8'h33};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 10'h00D, 8'h00, 1'b1, 10'h000, 1'b1, 8'h99, 1'b1, 8'h33};

        // Reset state.
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle_a();
        idle_b();
        repeat (3) tick();
        check("rst_dout0_a", dout0_a, 8'h00);
        check("rst_dout1_a", dout1_a, 8'h00);
        check("rst_busy_a", init_busy_a, 1'b1);
        check("rst_busy_b", init_busy_b, 1'b0);
        check("rst_dout0_b", dout0_b, 32'h0);
        check("rst_dout1_b", dout1_b, 32'h0);

        // Clear sequencer length and cleared contents.
        rst_a = 1'b0;
        rst_b = 1'b0;
        clear_run(n);
        check("clear_len", n, 1024);
        check("busy_b_idle", init_busy_b, 1'b0);
        drive_a(1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 10'h1FF);
        tick();
        check("clr_rd_000", dout0_a, 8'h00);
        check("clr_rd_1ff", dout1_a, 8'h00);
        drive_a(1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1, 10'h000);
        tick();
        check("clr_rd_3ff", dout0_a, 8'h00);

        // Table-driven vectors on instance a.
        for (int i = 0; i < NVEC; i++) begin
            drive_a(vecs[i].csb0, vecs[i].web0, vecs[i].wm, vecs[i].a0,
                    vecs[i].d0, vecs[i].csb1, vecs[i].a1);
            tick();
            if (vecs[i].chk0) check($sformatf("vec%0d_dout0", i), dout0_a, vecs[i].e0);
            if (vecs[i].chk1) check($sformatf("vec%0d_dout1", i), dout1_a, vecs[i].e1);
        end
        idle_a();

        // Masked write, latency 2 on port1.
        drive_b(1'b0, 1'b0, 4'hF, 10'h005, 32'h0, 1'b1, 10'h000);
        tick();
        drive_b(1'b0, 1'b0, 4'hF, 10'h020, 32'hAABBCCDD, 1'b1, 10'h000);
        tick();
        drive_b(1'b0, 1'b0, 4'b0101, 10'h020, 32'h11223344, 1'b1, 10'h000);
        tick();
        drive_b(1'b1, 1'b1, 4'h0, 10'h000, 32'h0, 1'b0, 10'h020);
        tick();
        check("mask_lat2_first", dout1_b, 32'h0);
        idle_b();
        tick();
        check("mask_merge", dout1_b, 32'hAA22CC44);

        // Latency 2 on port0: single launch then back-to-back.
        drive_b(1'b0, 1'b0, 4'hF, 10'h00A, 32'h55, 1'b1, 10'h000);
        tick();
        drive_b(1'b0, 1'b0, 4'hF, 10'h00B, 32'h44, 1'b1, 10'h000);
        tick();
        drive_b(1'b0, 1'b1, 4'h0, 10'h00A, 32'h0, 1'b1, 10'h000);
        tick();
        check("lat2_edge1", dout0_b, 32'h0);
        drive_b(1'b0, 1'b1, 4'h0, 10'h00B, 32'h0, 1'b1, 10'h000);
        tick();
        check("lat2_edge2", dout0_b, 32'h55);
        idle_b();
        tick();
        check("lat2_b2b", dout0_b, 32'h44);
        tick();
        check("lat2_hold", dout0_b, 32'h44);

        // Collision without bypass returns the old word, then the new one.
        drive_b(1'b0, 1'b0, 4'hF, 10'h005, 32'hA5, 1'b0, 10'h005);
        tick();
        idle_b();
        tick();
        check("nobyp_old", dout1_b, 32'h0);
        drive_b(1'b1, 1'b1, 4'h0, 10'h000, 32'h0, 1'b0, 10'h005);
        tick();
        idle_b();
        tick();
        check("nobyp_new", dout1_b, 32'hA5);

        // Reset in the middle of the clear sequence.
        drive_a(1'b0, 1'b0, 1'b1, 10'h3FF, 8'h99, 1'b1, 10'h000);
        tick();
        drive_a(1'b0, 1'b0, 1'b1, 10'h1FF, 8'h99, 1'b1, 10'h000);
        tick();
        drive_a(1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 10'h1FF);
        tick();
        check("pre_rd_3ff", dout0_a, 8'h99);
        check("pre_rd_1ff", dout1_a, 8'h99);
        idle_a();
        rst_a = 1'b1;
        #1;
        check("rst2_dout0", dout0_a, 8'h00);
        check("rst2_busy", init_busy_a, 1'b1);
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 100) drive_a(1'b0, 1'b0, 1'b1, 10'h010, 8'hFF, 1'b1, 10'h000);
            else idle_a();
        end
        idle_a();
        check("mid_busy", init_busy_a, 1'b1);
        rst_a = 1'b1;
        #1;
        check("mid_rst_busy", init_busy_a, 1'b1);
        tick();
        tick();
        rst_a = 1'b0;
        clear_run(n);
        check("restart_len", n, 1024);
        drive_a(1'b0, 1'b1, 1'b0, 10'h010, 8'h00, 1'b0, 10'h3FF);
        tick();
        check("ign_wr_010", dout0_a, 8'h00);
        check("reclr_3ff", dout1_a, 8'h00);
        drive_a(1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 10'h1FF);
        tick();
        check("reclr_1ff", dout1_a, 8'h00);
        idle_a();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_param.md
Name: sram_1rw1r_param

Overview:
- Parametrised single-clock behavioural model of a 1RW+1R SRAM macro. Generalises the fixed 8x1024 sky130 macro model to any data width, depth and write-mask granularity.
- Adds selectable read latency, defined port-0-write/port-1-read collision forwarding, and an optional post-reset memory-clear sequencer.
- Used as the backing store for MAC RX/TX frame buffers and in simulation in place of the hard macro.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH.
- MASK_WIDTH, 1, write-mask lanes. DATA_WIDTH % MASK_WIDTH must be 0; lane width = DATA_WIDTH/MASK_WIDTH.
- READ_LATENCY, 1, read latency in clock edges; legal values 1 or 2.
- BYPASS, 1, same-edge port0 write / port1 read to the same address: 1 = port1 returns new data, 0 = port1 returns old data.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset release before accepting accesses.

Ports:
- clk  input  1  single clock for both ports; all events on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- csb0  input  1  port0 chip select, active low.
- web0  input  1  port0 write enable, active low (0 = write, 1 = read).
- wmask0  input  MASK_WIDTH  port0 lane write enables, active high.
- addr0  input  ADDR_WIDTH  port0 address.
- din0  input  DATA_WIDTH  port0 write data.
- dout0  output  DATA_WIDTH  port0 read data.
- csb1  input  1  port1 chip select, active low.
- addr1  input  ADDR_WIDTH  port1 read address.
- dout1  output  DATA_WIDTH  port1 read data.
- init_busy  output  1  high while the clear sequencer runs; all accesses are ignored while high.

Behaviour:
- Reset state: dout0=0, dout1=0, all pipeline valid flags=0, clear counter=0.
  - init_busy=1 if CLEAR_ON_RESET=1, else 0.
  - Array contents are not touched by rst itself.
- FSM has two states, CLEAR and READY.
  - rst enters CLEAR when CLEAR_ON_RESET=1, else READY.
  - CLEAR: each edge writes 0 to mem[cnt] and increments cnt.
  - The edge that writes mem[DEPTH-1] moves the FSM to READY. init_busy drops after exactly DEPTH edges following rst deassert.
  - Reset asserted mid-CLEAR restarts from cnt=0.
- During CLEAR:
  - csb0/csb1 are ignored: no writes, no read launches.
  - dout0/dout1 hold their value (0).
- Port0 write, READY and csb0=0 and web0=0:
  - For each lane i with wmask0[i]=1, mem[addr0] lane i <= din0 lane i. Other lanes are unchanged.
  - dout0 holds its previous value; no read is launched.
- Port0 read, csb0=0 and web0=1: launches a read of mem[addr0].
- Port1 read, csb1=0: launches a read of mem[addr1].
- READ_LATENCY=1: data lands in dout at the launch edge (visible after that edge).
- READ_LATENCY=2: stage1 captures at the launch edge; dout loads from stage1 on the next edge, only if stage1 was valid. Otherwise dout holds.
- Deselected (csb=1) cycles launch nothing. dout holds its last read value indefinitely; reads are never cleared to X.
- Collision (port0 write and port1 read, same edge, same address):
  - BYPASS=1: port1 sees the merged word (written lanes new, unwritten lanes old).
  - BYPASS=0: port1 sees the pre-write word.
- Port0 read and port1 read of the same address: both return the same word.
- Address arithmetic wraps modulo DEPTH; no out-of-range handling is needed.
- Parameter violations (READ_LATENCY not 1 or 2; DATA_WIDTH not divisible by MASK_WIDTH) are flagged at elaboration with $error.

Test Plan:
- Clear sequencer (defaults, DEPTH=1024):
  - Release rst -> init_busy high for exactly 1024 edges, then 0.
  - Reads of addr 0x000, 0x1FF and 0x3FF then return 0x00.
- Basic RW (8x1024, latency 1):
  - Write 0x55@0x00A, 0x44@0x00B, 0x33@0x00C.
  - Idle 4 cycles, then read each on port0 -> dout0 = 0x55, 0x44, 0x33, each valid after its read edge.
  - dout0 holds 0x33 while csb0=1.
- Masked write (DATA_WIDTH=32, MASK_WIDTH=4):
  - Write 0xAABBCCDD with mask 4'b1111, then 0x11223344 with mask 4'b0101 -> port1 read returns 0xAA22CC44.
- Collision (addr 0x005 initially 0x00): port0 writes 0xA5 while port1 reads 0x005 on the same edge.
  - BYPASS=1 -> dout1=0xA5.
  - BYPASS=0 -> dout1=0x00; a following read returns 0xA5.
- READ_LATENCY=2:
  - Read 0x00A (holding 0x55) -> dout0 changes to 0x55 on the second edge after launch, not the first.
  - Back-to-back reads of 0x00A and 0x00B produce 0x55 then 0x44 on consecutive edges.
- Reset mid-clear:
  - Assert rst after 300 clear edges -> init_busy stays 1, counter restarts.
  - After release, init_busy stays high a full 1024 edges.
  - A write of 0xFF@0x010 attempted during clear is ignored; reading 0x010 afterwards returns 0x00.
